// File: rtl/instr_loader.sv
// Byte-stream instruction loader: sync byte, 16-bit LE word count, LE 32-bit words -> CPU write port.
// Define INSTR_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before CPU release.
module instr_loader #(
  parameter int unsigned MAX_WORDS      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        byte_ready_o,
  output logic        wr_instr_en_o,
  output logic [31:0] wr_instr_o,
  output logic [15:0] wr_addr_o,
  output logic        cpu_rst_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [15:0] word_cnt_o,
  output logic [2:0]  dbg_state_o
);
  // Handshake: byte_ready_o is always 1, so a byte transfers on every posedge where byte_valid_i=1.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CHK    = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam state_t S_FINAL = S_CHK;
`else
  localparam state_t S_FINAL = S_DONE;
`endif

  localparam int unsigned TO_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]     MAX_W   = 16'(MAX_WORDS);

  state_t            r_state;
  state_t            w_state_next;
  logic [15:0]       r_len;
  logic [23:0]       r_word;
  logic [1:0]        r_byte_idx;
  logic [15:0]       r_word_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_wr_en;
  logic [31:0]       r_wr_instr;
  logic [15:0]       r_wr_addr;

  logic              w_accept;
  logic              w_sync;
  logic              w_active;
  logic              w_timeout;
  logic              w_start;
  logic              w_word_done;
  logic              w_last_word;
  logic [15:0]       w_len_new;

  assign w_accept    = byte_valid_i;
  assign w_sync      = (byte_i == SYNC_BYTE);
  assign w_active    = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
                       (r_state == S_DATA)   || (r_state == S_CHK);
  // An accepted byte on the limit cycle wins over the timeout.
  assign w_timeout   = w_active && !w_accept && (r_to_cnt == TO_LAST);
  assign w_len_new   = {byte_i, r_len[7:0]};
  assign w_last_word = ((r_word_cnt + 16'd1) == r_len);

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0] r_csum;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_csum <= 8'h00;
    end else if (w_start) begin
      r_csum <= 8'h00;
    end else if (w_accept && ((r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
                              (r_state == S_DATA))) begin
      r_csum <= r_csum ^ byte_i;
    end
  end
`endif

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_word_done  = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (w_accept && w_sync) begin
          w_state_next = S_LEN_LO;
          w_start      = 1'b1;
        end
      end
      S_LEN_LO: begin
        if (w_accept) w_state_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (w_accept) begin
          if (w_len_new == 16'd0)     w_state_next = S_FINAL;
          else if (w_len_new > MAX_W) w_state_next = S_ERROR;
          else                        w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_accept && (r_byte_idx == 2'd3)) begin
          w_word_done = 1'b1;
          if (w_last_word) w_state_next = S_FINAL;
        end
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (w_accept) w_state_next = (byte_i == r_csum) ? S_DONE : S_ERROR;
      end
`endif
      default: w_state_next = S_IDLE;
    endcase
    if (w_timeout) w_state_next = S_ERROR;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_len      <= 16'd0;
      r_word     <= 24'd0;
      r_byte_idx <= 2'd0;
      r_word_cnt <= 16'd0;
      r_to_cnt   <= '0;
      r_wr_en    <= 1'b0;
      r_wr_instr <= 32'd0;
      r_wr_addr  <= 16'd0;
    end else begin
      r_state <= w_state_next;
      r_wr_en <= w_word_done;
      if (w_word_done) begin
        r_wr_instr <= {byte_i, r_word};
        r_wr_addr  <= r_word_cnt;
      end
      // The count advances at the end of the strobe cycle; a new frame start takes priority.
      if (w_start)      r_word_cnt <= 16'd0;
      else if (r_wr_en) r_word_cnt <= r_word_cnt + 16'd1;
      if (w_accept || !w_active) r_to_cnt <= '0;
      else                       r_to_cnt <= r_to_cnt + TO_W'(1);
      if (w_start) r_byte_idx <= 2'd0;
      if (w_accept) begin
        case (r_state)
          S_LEN_LO: r_len[7:0]  <= byte_i;
          S_LEN_HI: r_len[15:8] <= byte_i;
          S_DATA: begin
            r_byte_idx <= r_byte_idx + 2'd1;
            case (r_byte_idx)
              2'd0:    r_word[7:0]   <= byte_i;
              2'd1:    r_word[15:8]  <= byte_i;
              2'd2:    r_word[23:16] <= byte_i;
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  assign byte_ready_o  = 1'b1;
  assign wr_instr_en_o = r_wr_en;
  assign wr_instr_o    = r_wr_instr;
  assign wr_addr_o     = r_wr_addr;
  assign cpu_rst_o     = !((r_state == S_DONE) && !(w_accept && w_sync));
  assign busy_o        = w_active;
  assign done_o        = (r_state == S_DONE);
  assign error_o       = (r_state == S_ERROR);
  assign word_cnt_o    = r_word_cnt;
  assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: byte-level frame parser model, per-cycle compare process, directed + random frames.
// Follows INSTR_LOADER_CHECKSUM_EN to append and model the trailing checksum byte.
module tb_instr_loader;
  localparam int unsigned MAX_WORDS = 1024;
  localparam int unsigned TIMEOUT   = 16;
  localparam logic [7:0]  SYNC      = 8'hA5;
  localparam int M_IDLE = 0, M_LO = 1, M_HI = 2, M_DATA = 3, M_CHK = 4, M_DONE = 5, M_ERR = 6;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        byte_valid_i;
  logic [7:0]  byte_i;
  logic        byte_ready_o;
  logic        wr_instr_en_o;
  logic [31:0] wr_instr_o;
  logic [15:0] wr_addr_o;
  logic        cpu_rst_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic [15:0] word_cnt_o;
  logic [2:0]  dbg_state_o;

  always #5 clk = ~clk;

  instr_loader #(.MAX_WORDS(MAX_WORDS), .TIMEOUT_CYCLES(TIMEOUT), .SYNC_BYTE(SYNC)) dut (
    .clk_i(clk), .rst_i(rst_i), .byte_valid_i(byte_valid_i), .byte_i(byte_i),
    .byte_ready_o(byte_ready_o), .wr_instr_en_o(wr_instr_en_o), .wr_instr_o(wr_instr_o),
    .wr_addr_o(wr_addr_o), .cpu_rst_o(cpu_rst_o), .busy_o(busy_o), .done_o(done_o),
    .error_o(error_o), .word_cnt_o(word_cnt_o), .dbg_state_o(dbg_state_o)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [47:0] exp_q[$];
  logic [47:0] obs_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  m_part[$];
  int          m_mode, m_len, m_cnt, idle_run;
  logic [7:0]  m_csum;
  logic [47:0] m_shown;
  logic        exp_cpu_rst;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic bit m_busy();
    return (m_mode == M_LO) || (m_mode == M_HI) || (m_mode == M_DATA) || (m_mode == M_CHK);
  endfunction

  task automatic m_frame_end();
`ifdef INSTR_LOADER_CHECKSUM_EN
    m_mode = M_CHK;
`else
    m_mode = M_DONE;
`endif
  endtask

  // Reference parser: consumes one accepted byte, queues the writes the frame must produce.
  task automatic model_byte(input logic [7:0] b);
    case (m_mode)
      M_LO: begin m_len = int'(b); m_csum ^= b; m_mode = M_HI; end
      M_HI: begin
        m_len += 256 * int'(b);
        m_csum ^= b;
        if (m_len == 0) m_frame_end();
        else if (m_len > int'(MAX_WORDS)) m_mode = M_ERR;
        else begin m_mode = M_DATA; m_part.delete(); end
      end
      M_DATA: begin
        m_csum ^= b;
        m_part.push_back(b);
        if (m_part.size() == 4) begin
          exp_q.push_back({16'(m_cnt), m_part[3], m_part[2], m_part[1], m_part[0]});
          m_cnt++;
          m_part.delete();
          if (m_cnt == m_len) m_frame_end();
        end
      end
      M_CHK: m_mode = (b == m_csum) ? M_DONE : M_ERR;
      default: if (b == SYNC) begin m_mode = M_LO; m_cnt = 0; m_csum = 8'h00; end
    endcase
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_len = 0; m_cnt = 0; m_csum = 8'h00; idle_run = 0;
    m_shown = 48'd0;
    m_part.delete();
    exp_q.delete();
  endtask

  task automatic idle_cycle();
    byte_valid_i = 1'b0;
    @(posedge clk); #1;
    idle_run++;
    if (idle_run == int'(TIMEOUT) && m_busy()) begin m_mode = M_ERR; m_part.delete(); end
  endtask

  task automatic settle(input int n);
    repeat (n) idle_cycle();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) idle_cycle();
    byte_valid_i = 1'b1;
    byte_i = b;
    @(posedge clk); #1;
    byte_valid_i = 1'b0;
    idle_run = 0;
    model_byte(b);
  endtask

  task automatic send_tx(input int max_gap);
    foreach (tx_q[i]) send_byte(tx_q[i], $urandom_range(0, max_gap));
    tx_q.delete();
  endtask

  task automatic do_reset(input int cycles);
    rst_i = 1'b1;
    byte_valid_i = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 rst_i = 1'b0;
    model_reset();
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_ctl"}, 64'({byte_ready_o, wr_instr_en_o, cpu_rst_o, busy_o, done_o, error_o}),
        64'(6'b101000));
    chk({tag, "_wr"}, 64'({wr_addr_o, wr_instr_o}), 64'(0));
    chk({tag, "_cnt"}, 64'(word_cnt_o), 64'(0));
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (!rst_i) begin
      exp_cpu_rst = !(m_mode == M_DONE && !(byte_valid_i && byte_i == SYNC));
      chk("status", 64'({byte_ready_o, busy_o, done_o, error_o, cpu_rst_o}),
          64'({1'b1, m_busy(), m_mode == M_DONE, m_mode == M_ERR, exp_cpu_rst}));
      if (exp_q.size() == 0) chk("word_cnt", 64'(word_cnt_o), 64'(m_cnt));
      if (wr_instr_en_o) begin
        obs_q.push_back({wr_addr_o, wr_instr_o});
        if (exp_q.size() == 0) chk("unexpected_wr", 64'(wr_instr_en_o), 64'(0));
        else begin
          m_shown = exp_q.pop_front();
          chk("wr", 64'({wr_addr_o, wr_instr_o}), 64'(m_shown));
        end
      end else begin
        chk("wr_hold", 64'({wr_addr_o, wr_instr_o}), 64'(m_shown));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, long_at, gap;
    logic [7:0] b, cs;
    rst_i = 1'b1; byte_valid_i = 1'b0; byte_i = 8'h00;
    model_reset();
    do_reset(3);
    chk_reset_values("reset");

    // Basic two-word load.
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'hC5, 8'h00};
`ifdef INSTR_LOADER_CHECKSUM_EN
    tx_q.push_back(8'h67);
`endif
    obs_q.delete();
    send_tx(2);
    settle(3);
    chk("basic_nwr", 64'(obs_q.size()), 64'(2));
    if (obs_q.size() == 2) begin
      chk("basic_wr0", 64'(obs_q[0]), 64'({16'd0, 32'h00000013}));
      chk("basic_wr1", 64'(obs_q[1]), 64'({16'd1, 32'h00C500B3}));
    end
    chk("basic_end", 64'({done_o, cpu_rst_o, error_o}), 64'(3'b100));
    chk("basic_cnt", 64'(word_cnt_o), 64'(2));

    // Garbage then zero length.
    tx_q = '{8'h11, 8'h22, 8'hA5, 8'h00, 8'h00};
`ifdef INSTR_LOADER_CHECKSUM_EN
    tx_q.push_back(8'h00);
`endif
    obs_q.delete();
    send_tx(1);
    settle(3);
    chk("zero_nwr", 64'(obs_q.size()), 64'(0));
    chk("zero_end", 64'({done_o, cpu_rst_o, error_o}), 64'(3'b100));
    chk("zero_cnt", 64'(word_cnt_o), 64'(0));

    // Oversize count, then recovery.
    tx_q = '{8'hA5, 8'h01, 8'h04};
    send_tx(1);
    settle(3);
    chk("over_end", 64'({done_o, cpu_rst_o, error_o}), 64'(3'b011));
    chk("over_nwr", 64'(obs_q.size()), 64'(0));
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
`ifdef INSTR_LOADER_CHECKSUM_EN
    tx_q.push_back(8'h01);
`endif
    send_tx(1);
    settle(3);
    chk("recover_nwr", 64'(obs_q.size()), 64'(1));
    if (obs_q.size() == 1) chk("recover_wr", 64'(obs_q[0]), 64'({16'd0, 32'hDDCCBBAA}));
    chk("recover_end", 64'({done_o, cpu_rst_o, error_o}), 64'(3'b100));

    // Timeout after TIMEOUT idle cycles; one fewer is tolerated.
    obs_q.delete();
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'h13};
    send_tx(0);
    settle(int'(TIMEOUT) - 1);
    chk("to_before", 64'({busy_o, error_o}), 64'(2'b10));
    idle_cycle();
    chk("to_hit", 64'({error_o, cpu_rst_o, busy_o}), 64'(3'b110));
    settle(2);
    chk("to_nwr", 64'(obs_q.size()), 64'(0));
    tx_q = '{8'hA5, 8'h01, 8'h00};
    send_tx(0);
    send_byte(8'h13, int'(TIMEOUT) - 1);
    tx_q = '{8'h00, 8'h00, 8'h00};
`ifdef INSTR_LOADER_CHECKSUM_EN
    tx_q.push_back(8'h12);
`endif
    send_tx(0);
    settle(2);
    chk("to_edge_end", 64'({done_o, error_o, cpu_rst_o}), 64'(3'b100));
    chk("to_edge_nwr", 64'(obs_q.size()), 64'(1));

`ifdef INSTR_LOADER_CHECKSUM_EN
    // Bad checksum: word still written, CPU stays in reset.
    obs_q.delete();
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h00};
    send_tx(1);
    settle(2);
    chk("csum_bad_end", 64'({done_o, error_o, cpu_rst_o}), 64'(3'b011));
    chk("csum_bad_nwr", 64'(obs_q.size()), 64'(1));
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
    send_tx(1);
    settle(2);
    chk("csum_ok_end", 64'({done_o, error_o, cpu_rst_o}), 64'(3'b100));
`endif

    // Reload reasserts CPU reset combinationally; reset mid-frame drops the partial word.
    chk("done_cpu_rst", 64'(cpu_rst_o), 64'(0));
    obs_q.delete();
    byte_valid_i = 1'b1;
    byte_i = SYNC;
    #1 chk("reload_cpu_rst", 64'(cpu_rst_o), 64'(1));
    send_byte(SYNC, 0);
    tx_q = '{8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_tx(1);
    do_reset(1);
    chk_reset_values("midreset");
    settle(2);
    chk("midreset_nwr", 64'(obs_q.size()), 64'(1));
    if (obs_q.size() == 1) chk("midreset_wr0", 64'(obs_q[0]), 64'({16'd0, 32'h04030201}));

    // Random frames: garbage, oversize counts, SYNC-valued data, occasional long gaps.
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 3) == 0) begin
        b = 8'($urandom_range(0, 255));
        if (b == SYNC) b = 8'h00;
        tx_q.push_back(b);
      end
      len = ($urandom_range(0, 9) == 0) ? int'(MAX_WORDS) + 1 + int'($urandom_range(0, 200))
                                        : int'($urandom_range(0, 4));
      tx_q.push_back(SYNC);
      tx_q.push_back(8'(len));
      tx_q.push_back(8'(len >> 8));
      cs = 8'(len) ^ 8'(len >> 8);
      if (len <= int'(MAX_WORDS)) begin
        for (int k = 0; k < 4 * len; k++) begin
          b = ($urandom_range(0, 7) == 0) ? SYNC : 8'($urandom_range(0, 255));
          tx_q.push_back(b);
          cs ^= b;
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        tx_q.push_back(($urandom_range(0, 3) == 0) ? (cs ^ 8'h01) : cs);
`endif
      end
      long_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, tx_q.size() - 1)) : -1;
      foreach (tx_q[i]) begin
        gap = (i == long_at) ? int'($urandom_range(TIMEOUT - 1, TIMEOUT + 1))
                             : int'($urandom_range(0, 3));
        send_byte(tx_q[i], gap);
      end
      tx_q.delete();
    end
    settle(int'(TIMEOUT) + 4);
    chk("exp_q_drained", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
